alu_mul_seq: RTL and testbench

//  Initiator side of the 2-bit-opcode combinational ALU: drives OP/INPUTA/INPUTB on the ALU and consumes OUT/ZERO/EQUAL.

---
 rtl/alu_mul_seq_if.sv | 26 ++
 rtl/alu_mul_seq.sv | 121 ++++++++++++
 tb/tb_alu_mul_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_seq_if.sv
// Request/response bus of the ALU sequencer: operands and mode in, registered result and flags out.
// start is honoured only on an edge where ready=1; valid pulses for exactly one cycle once result/flags are updated.
interface alu_mul_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             mode;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] result;
    logic             zero_f;
    logic             equal_f;

    modport master (
        output start, mode, op, opa, opb,
        input  ready, valid, result, zero_f, equal_f
    );

    modport slave (
        input  start, mode, op, opa, opb,
        output ready, valid, result, zero_f, equal_f
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Initiator for a combinational 2-bit-opcode ALU: either one ALU op, or a shift-add
// multiply (low WIDTH bits) built by iterating ADD on that same ALU.
module alu_mul_seq #(
    parameter int WIDTH      = 16,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    alu_mul_seq_if.slave     bus,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_equal,
    output logic [1:0]       dbg_state
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] K_ADD = 2'd0;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t           state;
    logic             ready_r;
    logic             valid_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             equal_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_next;
    logic             run_last;

    // Outside RUN the ALU sees the caller's operands so a MODE=0 request completes on the accepting edge.
    always_comb begin
        alu_op = bus.op;
        alu_a  = bus.opa;
        alu_b  = bus.opb;
        if (state == S_RUN) begin
            alu_op = K_ADD;
            alu_a  = acc;
            alu_b  = mcand;
        end
    end

    assign acc_next = mplier[0] ? alu_out : acc;
    assign run_last = ((EARLY_EXIT != 0) && ((mplier >> 1) == '0)) || (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
            result_r <= '0;
            zero_r   <= 1'b0;
            equal_r  <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        ready_r <= 1'b0;
                        if (!bus.mode) begin
                            result_r <= alu_out;
                            zero_r   <= alu_zero;
                            equal_r  <= alu_equal;
                            valid_r  <= 1'b1;
                            state    <= S_DONE;
                        end else if ((EARLY_EXIT != 0) && (bus.opb == '0)) begin
                            result_r <= '0;
                            zero_r   <= 1'b1;
                            equal_r  <= 1'b0;
                            valid_r  <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            acc    <= '0;
                            mcand  <= bus.opa;
                            mplier <= bus.opb;
                            cnt    <= '0;
                            state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (run_last) begin
                        result_r <= acc_next;
                        zero_r   <= (acc_next == '0);
                        equal_r  <= 1'b0;
                        valid_r  <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready_r <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = ready_r;
    assign bus.valid   = valid_r;
    assign bus.result  = result_r;
    assign bus.zero_f  = zero_r;
    assign bus.equal_f = equal_r;
    assign dbg_state   = state;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: two instances (early exit on/off) share stimulus; a monitor checks each VALID
// against a queue filled from an arithmetic reference model when each request is issued.
module tb_alu_mul_seq;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         e;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    logic [1:0]   alu_op0, alu_op1, dbg0, dbg1;
    logic [W-1:0] alu_a0, alu_b0, alu_a1, alu_b1, alu_out0, alu_out1;

    alu_mul_seq_if #(.WIDTH(W)) ifc0 ();
    alu_mul_seq_if #(.WIDTH(W)) ifc1 ();

    assign ifc0.start = start;
    assign ifc0.mode  = mode;
    assign ifc0.op    = op;
    assign ifc0.opa   = opa;
    assign ifc0.opb   = opb;
    assign ifc1.start = start;
    assign ifc1.mode  = mode;
    assign ifc1.op    = op;
    assign ifc1.opa   = opa;
    assign ifc1.opb   = opb;

    function automatic logic [W-1:0] alu_f(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_out0 = alu_f(alu_op0, alu_a0, alu_b0);
    assign alu_out1 = alu_f(alu_op1, alu_a1, alu_b1);

    alu_mul_seq #(.WIDTH(W), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .reset(reset), .bus(ifc0.slave),
        .alu_op(alu_op0), .alu_a(alu_a0), .alu_b(alu_b0),
        .alu_out(alu_out0), .alu_zero(alu_out0 == '0), .alu_equal(alu_a0 == alu_b0),
        .dbg_state(dbg0)
    );

    alu_mul_seq #(.WIDTH(W), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .reset(reset), .bus(ifc1.slave),
        .alu_op(alu_op1), .alu_a(alu_a1), .alu_b(alu_b1),
        .alu_out(alu_out1), .alu_zero(alu_out1 == '0), .alu_equal(alu_a1 == alu_b1),
        .dbg_state(dbg1)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // reference model: plain arithmetic on the request
    function automatic logic [W-1:0] ref_res(input logic m, input logic [1:0] o,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        if (!m) begin
            case (o)
                2'd0:    return a + b;
                2'd1:    return a - b;
                2'd2:    return a & b;
                default: return a ^ b;
            endcase
        end
        p = (2*W)'(a) * (2*W)'(b);
        return p[W-1:0];
    endfunction

    function automatic int ref_lat(input logic m, input logic [W-1:0] b, input bit early);
        if (!m) return 0;
        if (!early) return W;
        for (int i = W - 1; i >= 0; i--)
            if (b[i]) return i + 1;
        return 0;
    endfunction

    // driver tasks
    task automatic wait_ready();
        int n = 0;
        while (!(ifc0.ready && ifc1.ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic m, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        wait_ready();
        mode = m; op = o; opa = a; opb = b; start = 1'b1;
        e.res = ref_res(m, o, a, b);
        e.z   = (e.res == '0);
        e.e   = m ? 1'b0 : (a == b);
        e.cyc = cyc + 1 + ref_lat(m, b, 1'b1);
        exp_q0.push_back(e);
        e.cyc = cyc + 1 + ref_lat(m, b, 1'b0);
        exp_q1.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // scoreboard monitor
    task automatic check_valid(input int k, input logic [W-1:0] res, input logic z, input logic e, input logic rdy);
        exp_t x;
        if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            chk($sformatf("unexpected_valid%0d", k), 32'd1, 32'd0);
            return;
        end
        if (k == 0) x = exp_q0.pop_front();
        else        x = exp_q1.pop_front();
        chk($sformatf("result%0d", k), 32'(res), 32'(x.res));
        chk($sformatf("zero%0d", k), 32'(z), 32'(x.z));
        chk($sformatf("equal%0d", k), 32'(e), 32'(x.e));
        chk($sformatf("valid_cycle%0d", k), 32'(cyc), 32'(x.cyc));
        chk($sformatf("ready_in_done%0d", k), 32'(rdy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (ifc0.valid) check_valid(0, ifc0.result, ifc0.zero_f, ifc0.equal_f, ifc0.ready);
        if (ifc1.valid) check_valid(1, ifc1.result, ifc1.zero_f, ifc1.equal_f, ifc1.ready);
    end

    task automatic check_idle_reset(input string tag);
        chk({tag, "_ready0"}, 32'(ifc0.ready), 32'd1);
        chk({tag, "_valid0"}, 32'(ifc0.valid), 32'd0);
        chk({tag, "_result0"}, 32'(ifc0.result), 32'd0);
        chk({tag, "_zero0"}, 32'(ifc0.zero_f), 32'd0);
        chk({tag, "_ready1"}, 32'(ifc1.ready), 32'd1);
        chk({tag, "_result1"}, 32'(ifc1.result), 32'd0);
    endtask

    initial begin
        int n;
        logic [W-1:0] a, b;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_reset("reset");
        chk("reset_equal0", 32'(ifc0.equal_f), 32'd0);

        // single-op cases, including equal operands and wraparound add
        issue(1'b0, 2'd1, 16'd5, 16'd5);
        @(negedge clk);
        chk("ready_after_done", 32'(ifc0.ready), 32'd1);
        issue(1'b0, 2'd0, 16'hFFFF, 16'h0001);
        issue(1'b0, 2'd2, 16'hF0F0, 16'h3C3C);
        issue(1'b0, 2'd3, 16'h1234, 16'h1234);

        // multiply: ALU must be forced to ADD while running even though op is XOR
        issue(1'b1, 2'd3, 16'd7, 16'd6);
        chk("run_alu_op_add", 32'(alu_op0), 32'd0);
        issue(1'b1, 2'd3, 16'h0100, 16'h0100);
        issue(1'b1, 2'd1, 16'h1234, 16'h0000);
        issue(1'b1, 2'd2, 16'hFFFF, 16'hFFFF);
        issue(1'b1, 2'd0, 16'h8001, 16'h8000);

        // starts while busy are dropped; dut0 runs 8 cycles for multiplier 0x00F3
        issue(1'b1, 2'd0, 16'h1234, 16'h00F3);
        for (int i = 0; i < 8; i++) begin
            opa = 16'($urandom); opb = 16'($urandom); mode = 1'($urandom); start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;

        // reset on the second run cycle aborts the request
        issue(1'b1, 2'd0, 16'h00AB, 16'hFFFF);
        @(negedge clk);
        reset = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        reset = 1'b0;
        check_idle_reset("abort");
        issue(1'b0, 2'd3, 16'hF0F0, 16'h0FF0);

        // random traffic, biased so both short and long multipliers occur
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = b;
            issue(1'($urandom), 2'($urandom_range(0, 3)), a, b);
        end

        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pending0", 32'(exp_q0.size()), 32'd0);
        chk("pending1", 32'(exp_q1.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
